// File: rtl/pbs_hp_datapath.sv
// HP datapath for the battle engine: holds both HP registers and drains
// move damage one point per DRAIN_TICKS cycles so the HP bar animates.
module pbs_hp_datapath #(
    parameter int HP_W        = 8,
    parameter int POWER_W     = 6,
    parameter int MAX_HP      = 100,
    parameter int DRAIN_TICKS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_ai_hp,
    input  logic               load_p_hp,
    input  logic               apply_ai_damage,
    input  logic               apply_p_damage,
    input  logic               active_trainer,
    input  logic               target,
    input  logic [POWER_W-1:0] p_move_power,
    input  logic [POWER_W-1:0] ai_move_power,
    output logic [HP_W-1:0]    p_hp,
    output logic [HP_W-1:0]    ai_hp,
    output logic               p_fainted,
    output logic               ai_fainted,
    output logic               busy,
    output logic               done,
    output logic               target_err
);

    localparam int TICKS = (DRAIN_TICKS < 1) ? 1 : DRAIN_TICKS;
    localparam int CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int CMP_W = (HP_W > POWER_W) ? HP_W : POWER_W;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DRAIN,
        DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               victim_q;
    logic               tgt_q;
    logic [POWER_W-1:0] power_q;
    logic [HP_W-1:0]    rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [HP_W-1:0]    p_hp_q;
    logic [HP_W-1:0]    ai_hp_q;

    logic               load;
    logic               apply;
    logic               tick;
    logic [HP_W-1:0]    victim_hp;
    logic [CMP_W-1:0]   power_ext;
    logic [CMP_W-1:0]   hp_ext;
    logic [CMP_W-1:0]   dmg_ext;
    logic [HP_W-1:0]    dmg;

    assign load  = load_ai_hp | load_p_hp;
    assign apply = apply_ai_damage | apply_p_damage;
    assign tick  = (cnt_q == CNT_W'(TICKS - 1));

    // Damage saturates at the victim's current HP so HP never wraps.
    assign victim_hp = victim_q ? ai_hp_q : p_hp_q;
    assign power_ext = CMP_W'(power_q);
    assign hp_ext    = CMP_W'(victim_hp);
    assign dmg_ext   = (power_ext < hp_ext) ? power_ext : hp_ext;
    assign dmg       = HP_W'(dmg_ext);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (apply) begin
                        state_d = CALC;
                    end
                end
                CALC: begin
                    state_d = (dmg == '0) ? DONE : DRAIN;
                end
                DRAIN: begin
                    if (tick && rem_q == HP_W'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            victim_q <= 1'b0;
            tgt_q    <= 1'b0;
            power_q  <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            p_hp_q   <= HP_W'(MAX_HP);
            ai_hp_q  <= HP_W'(MAX_HP);
        end else if (load) begin
            // Loads abort; the other Pokemon keeps its partially drained HP.
            if (load_p_hp) begin
                p_hp_q <= HP_W'(MAX_HP);
            end
            if (load_ai_hp) begin
                ai_hp_q <= HP_W'(MAX_HP);
            end
            rem_q <= '0;
            cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (apply) begin
                        victim_q <= apply_ai_damage;
                        tgt_q    <= target;
                        power_q  <= active_trainer ? ai_move_power
                                                   : p_move_power;
                    end
                end
                CALC: begin
                    rem_q <= dmg;
                    cnt_q <= '0;
                end
                DRAIN: begin
                    if (tick) begin
                        cnt_q <= '0;
                        rem_q <= rem_q - HP_W'(1);
                        if (victim_q) begin
                            ai_hp_q <= ai_hp_q - HP_W'(1);
                        end else begin
                            p_hp_q <= p_hp_q - HP_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    cnt_q <= '0;
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    assign p_hp       = p_hp_q;
    assign ai_hp      = ai_hp_q;
    assign p_fainted  = (p_hp_q == '0);
    assign ai_fainted = (ai_hp_q == '0);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign target_err = (state_q == CALC) && (tgt_q != victim_q);

endmodule

// File: tb/tb_pbs_hp_datapath.sv
// Randomized bench for pbs_hp_datapath against a per-cycle HP timeline
// derived from the damage/latency rules.
module tb_pbs_hp_datapath;

    localparam int HP_W    = 8;
    localparam int POWER_W = 6;
    localparam int MAX_HP  = 100;
    localparam int DT      = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               load_ai_hp;
    logic               load_p_hp;
    logic               apply_ai_damage;
    logic               apply_p_damage;
    logic               active_trainer;
    logic               target;
    logic [POWER_W-1:0] p_move_power;
    logic [POWER_W-1:0] ai_move_power;
    logic [HP_W-1:0]    p_hp;
    logic [HP_W-1:0]    ai_hp;
    logic               p_fainted;
    logic               ai_fainted;
    logic               busy;
    logic               done;
    logic               target_err;

    int n_vec = 0;
    int n_err = 0;
    int ref_p;
    int ref_ai;

    pbs_hp_datapath #(
        .HP_W       (HP_W),
        .POWER_W    (POWER_W),
        .MAX_HP     (MAX_HP),
        .DRAIN_TICKS(DT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_ai_hp     (load_ai_hp),
        .load_p_hp      (load_p_hp),
        .apply_ai_damage(apply_ai_damage),
        .apply_p_damage (apply_p_damage),
        .active_trainer (active_trainer),
        .target         (target),
        .p_move_power   (p_move_power),
        .ai_move_power  (ai_move_power),
        .p_hp           (p_hp),
        .ai_hp          (ai_hp),
        .p_fainted      (p_fainted),
        .ai_fainted     (ai_fainted),
        .busy           (busy),
        .done           (done),
        .target_err     (target_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_hp(input string tag);
        chk({tag, "_p_hp"}, int'(p_hp), ref_p);
        chk({tag, "_ai_hp"}, int'(ai_hp), ref_ai);
        chk({tag, "_p_faint"}, int'(p_fainted), int'(ref_p == 0));
        chk({tag, "_ai_faint"}, int'(ai_fainted), int'(ref_ai == 0));
    endtask

    // One damage operation; abort_at >= 0 fires a load strobe at edge E1+abort_at.
    task automatic do_op(input bit sa, input bit sp, input bit at, input bit tg,
                         input int pp, input int ap, input int abort_at,
                         input bit abort_ai, input bit spur);
        int vic;
        int pw;
        int start;
        int dmg;
        int last;
        int cur;
        int steps;
        vic   = sa ? 1 : 0;
        pw    = at ? ap : pp;
        start = vic ? ref_ai : ref_p;
        dmg   = (pw < start) ? pw : start;
        last  = dmg * DT;
        cur   = start;
        apply_ai_damage = sa;
        apply_p_damage  = sp;
        active_trainer  = at;
        target          = tg;
        p_move_power    = POWER_W'(pp);
        ai_move_power   = POWER_W'(ap);
        step();
        apply_ai_damage = 1'b0;
        apply_p_damage  = 1'b0;
        chk("calc_busy", int'(busy), 1);
        chk("calc_done", int'(done), 0);
        chk("calc_terr", int'(target_err), int'(tg != vic[0]));
        for (int j = 0; j <= last + 1; j++) begin
            if (j == abort_at) begin
                if (abort_ai) load_ai_hp = 1'b1;
                else load_p_hp = 1'b1;
                step();
                load_ai_hp = 1'b0;
                load_p_hp  = 1'b0;
                if (vic == 1) ref_ai = cur;
                else ref_p = cur;
                if (abort_ai) ref_ai = MAX_HP;
                else ref_p = MAX_HP;
                chk("abort_busy", int'(busy), 0);
                chk("abort_done", int'(done), 0);
                chk_hp("abort");
                step();
                chk("abort_idle_done", int'(done), 0);
                chk_hp("abort_hold");
                return;
            end
            if (spur && j < last && $urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) apply_p_damage = 1'b1;
                else apply_ai_damage = 1'b1;
                p_move_power  = POWER_W'($urandom);
                ai_move_power = POWER_W'($urandom);
            end
            step();
            apply_ai_damage = 1'b0;
            apply_p_damage  = 1'b0;
            steps = j / DT;
            cur = start - ((steps < dmg) ? steps : dmg);
            if (vic == 1) ref_ai = cur;
            else ref_p = cur;
            chk_hp("drain");
            chk("drain_done", int'(done), int'(j == last));
            chk("drain_busy", int'(busy), int'(j <= last));
            chk("drain_terr", int'(target_err), 0);
        end
    endtask

    initial begin
        int cnt;
        reset           = 1'b1;
        load_ai_hp      = 1'b0;
        load_p_hp       = 1'b0;
        apply_ai_damage = 1'b0;
        apply_p_damage  = 1'b0;
        active_trainer  = 1'b0;
        target          = 1'b0;
        p_move_power    = '0;
        ai_move_power   = '0;
        ref_p  = MAX_HP;
        ref_ai = MAX_HP;
        step();
        step();
        reset = 1'b0;
        chk_hp("reset");
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_terr", int'(target_err), 0);

        // Player hits AI for 20.
        do_op(1, 0, 0, 1, 20, 0, -1, 0, 0);
        chk("ai_80", int'(ai_hp), 80);

        // Bring AI to 5, then saturate to 0.
        do_op(1, 0, 1, 1, 0, 63, -1, 0, 0);
        do_op(1, 0, 0, 1, 12, 0, -1, 0, 0);
        chk("ai_5", int'(ai_hp), 5);
        do_op(1, 0, 0, 1, 20, 0, -1, 0, 0);
        chk("ai_sat", int'(ai_hp), 0);
        chk("ai_faint", int'(ai_fainted), 1);

        // Zero power: busy for exactly CALC + DONE.
        do_op(0, 1, 1, 0, 0, 0, -1, 0, 0);

        // Both strobes: AI wins; spurious strobes mid-drain ignored.
        load_ai_hp = 1'b1;
        step();
        load_ai_hp = 1'b0;
        ref_ai = MAX_HP;
        chk_hp("reload_ai");
        do_op(1, 1, 0, 1, 15, 40, -1, 0, 1);

        // Load player HP mid-drain at 90 of a 30-point hit.
        do_op(0, 1, 1, 0, 0, 30, 10 * DT + 1, 0, 0);
        chk("load_mid_p", int'(p_hp), MAX_HP);

        // Target mismatch still drains the player.
        do_op(0, 1, 1, 1, 0, 7, -1, 0, 0);

        // Load together with apply in IDLE: apply dropped.
        load_ai_hp     = 1'b1;
        apply_p_damage = 1'b1;
        p_move_power   = POWER_W'(9);
        active_trainer = 1'b0;
        step();
        load_ai_hp     = 1'b0;
        apply_p_damage = 1'b0;
        ref_ai = MAX_HP;
        chk("load_apply_busy", int'(busy), 0);
        chk_hp("load_apply");
        step();
        chk("load_apply_idle", int'(busy), 0);

        cnt = 0;
        while (cnt < 30) begin
            bit sa;
            bit sp;
            int ab;
            int r;
            r  = $urandom_range(0, 2);
            sa = (r != 0);
            sp = (r != 1);
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 40) : -1;
            if (ref_p < 10 && ref_ai < 10) begin
                load_p_hp  = 1'b1;
                load_ai_hp = 1'b1;
                step();
                load_p_hp  = 1'b0;
                load_ai_hp = 1'b0;
                ref_p  = MAX_HP;
                ref_ai = MAX_HP;
                chk_hp("rnd_reload");
            end
            do_op(sa, sp, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 63), $urandom_range(0, 63),
                  ab, 1'($urandom), 1'($urandom));
            cnt++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pbs_hp_datapath.md
Name: pbs_hp_datapath

Overview:
- Battle datapath directly downstream of the battle control FSM.
- Consumes the FSM's control strobes: apply_p_damage, apply_ai_damage, active_trainer, target, load_ai_hp.
- Holds both Pokemon HP registers and applies move damage as a paced, one-point-per-step HP drain for on-screen animation.
- Returns HP values, faint flags and a done pulse to the FSM.

Parameters:
- HP_W, 8, width of each HP register.
- POWER_W, 6, width of the move-power inputs.
- MAX_HP, 100, HP value loaded at reset and by load strobes.
- DRAIN_TICKS, 4, clock cycles per 1-point HP decrement (min 1).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- load_ai_hp  in  1  pulse: ai_hp <= MAX_HP; aborts any operation.
- load_p_hp  in  1  pulse: p_hp <= MAX_HP; aborts any operation.
- apply_ai_damage  in  1  pulse: start damage with the AI Pokemon as victim.
- apply_p_damage  in  1  pulse: start damage with the player Pokemon as victim.
- active_trainer  in  1  attacker select: 0 = player, 1 = AI; sampled with the apply strobe.
- target  in  1  0 = player, 1 = AI; must match the victim; sampled with the apply strobe.
- p_move_power  in  POWER_W  player's selected move power.
- ai_move_power  in  POWER_W  AI's selected move power.
- p_hp  out  HP_W  current player HP.
- ai_hp  out  HP_W  current AI HP.
- p_fainted  out  1  high when p_hp == 0.
- ai_fainted  out  1  high when ai_hp == 0.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a damage operation completes.
- target_err  out  1  one-cycle pulse when target disagrees with the apply strobe.

Behaviour:
- Reset (sync, active-high):
  - p_hp = ai_hp = MAX_HP.
  - state = IDLE; busy = done = target_err = 0.
  - Tick counter and remaining-damage register cleared.
  - p_fainted and ai_fainted are combinational from the HP values, so both read 0.
- States are IDLE, CALC, DRAIN, DONE.
- IDLE:
  - On an edge with an apply strobe high, latch the victim, attacker power (active_trainer ? ai_move_power : p_move_power) and target, then go to CALC.
  - If both apply strobes are high, apply_ai_damage wins and apply_p_damage is dropped.
- CALC (1 cycle):
  - remaining <= min(power, victim HP), zero-extended to HP_W; saturates, so HP never underflows.
  - If the latched target does not match the victim: target_err pulses; damage is still applied to the apply-strobe victim.
  - If remaining computes to 0, go to DONE; otherwise go to DRAIN with the tick counter at 0.
- DRAIN:
  - The counter counts 0..DRAIN_TICKS-1.
  - On the edge where counter == DRAIN_TICKS-1: victim HP -= 1, remaining -= 1, counter <= 0.
  - When remaining reaches 0, go to DONE.
- DONE (1 cycle): done = 1, then IDLE.
- Latency: apply sampled at edge E0; CALC during E0..E1; HP reaches its final value at edge E1 + dmg*DRAIN_TICKS; done high for the following cycle.
- Apply strobes are ignored while busy (no queueing).
- Load strobes:
  - Honoured in any state and take priority over reset-free operation.
  - Return the state to IDLE and clear remaining and the counter; no done pulse.
  - The partially drained HP of the other Pokemon is kept.
- A load strobe together with an apply strobe in IDLE: the load is honoured and the apply is ignored.
- Faint flags follow HP combinationally; no sticky behaviour.

Test Plan:
- Reset asserted 2 cycles -> p_hp = ai_hp = 100, busy = 0, done = 0, fainted flags 0.
- apply_ai_damage = 1, target = 1, active_trainer = 0, p_move_power = 20, DRAIN_TICKS = 4 -> ai_hp decrements by 1 every 4 cycles, reaches 80 at E0+81, done pulses once, p_hp stays 100.
- ai_hp preloaded to 5 via 95 damage, then apply with power 20 -> ai_hp saturates at 0 after 5 steps, ai_fainted = 1, no wrap to 255.
- Power 0 apply -> CALC then DONE, done pulses at E0+2, HP unchanged, busy high exactly 2 cycles.
- Both apply strobes the same cycle with target = 1 -> only ai_hp drops; a second apply_p_damage pulse mid-drain is ignored.
- load_p_hp mid-drain of p_hp (at 90 of 70 target) -> p_hp = 100 next cycle, state IDLE, no done pulse.
- apply_p_damage with target = 1 -> target_err pulses once in CALC, p_hp still drained.
